// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout, FSM states.
package icache_direct_pkg;

    localparam int SETS  = 16;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Datapath fetch port and memory-control read port of the instruction cache, bundled as one interface.
interface icache_direct_if;
    import icache_direct_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-block instruction cache: zero-latency hits from the frame array,
// single-word refill from memory control on a miss, flush support with in-flight fill discard.
module icache_direct
    import icache_direct_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  bus
);

    icache_state_t state_r;
    word_t         miss_addr_r;
    logic          discard_r;
    icache_frame_t frames_r [SETS];

    icachef_t req_s;
    icachef_t miss_s;
    logic     match_s;
    logic     hit_s;

    assign req_s  = bus.imemaddr;
    assign miss_s = miss_addr_r;

    // Tag lookup; only iflush and state gate the hit, never the memory-side inputs.
    always_comb begin
        match_s = frames_r[req_s.idx].valid && (frames_r[req_s.idx].tag == req_s.tag);
        hit_s   = (state_r == IDLE) && bus.imemREN && match_s && !bus.iflush;
    end

    // Datapath-facing response; the word is forced to zero whenever there is no hit.
    always_comb begin
        bus.ihit = hit_s;
        if (hit_s) begin
            bus.imemload = frames_r[req_s.idx].data;
        end else begin
            bus.imemload = 32'h0000_0000;
        end
    end

    assign bus.iREN  = (state_r == FETCH);
    assign bus.iaddr = miss_addr_r;

    // Miss FSM and frame array; only valid bits are reset, tag/data are overwritten on fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            miss_addr_r <= 32'h0000_0000;
            discard_r   <= 1'b0;
            for (int i = 0; i < SETS; i++) begin
                frames_r[i].valid <= 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    discard_r <= 1'b0;
                    if (bus.iflush) begin
                        for (int i = 0; i < SETS; i++) begin
                            frames_r[i].valid <= 1'b0;
                        end
                        state_r <= IDLE;
                    end else if (bus.imemREN && !match_s) begin
                        miss_addr_r <= {bus.imemaddr[31:2], 2'b00};
                        state_r     <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (bus.iflush) begin
                        for (int i = 0; i < SETS; i++) begin
                            frames_r[i].valid <= 1'b0;
                        end
                        discard_r <= 1'b1;
                    end
                    // A flush seen before or during the completing cycle suppresses the write.
                    if (!bus.iwait) begin
                        if (!discard_r && !bus.iflush) begin
                            frames_r[miss_s.idx] <= '{valid: 1'b1, tag: miss_s.tag, data: bus.iload};
                        end
                        discard_r <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
